// File: rtl/calc_display_pkg.sv
// Types and defaults shared by the calculator result path and the hex display path.
// bin_to_bcd_seq and the display drivers both import this package.
package calc_display_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_DIGITS = 5;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the next shift,
// so the shifted digit carries into the next nibble instead of passing 9.
module bcd_digit_adj
  import calc_display_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary to BCD converter (shift-and-add-3), one bit per clock, fixed WIDTH-cycle latency.
// Define SIGNED_INPUT_EN to treat value as two's complement and report its sign on neg.
module bin_to_bcd_seq
  import calc_display_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  neg
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  conv_state_t        state;
  conv_state_t        state_next;
  logic [WIDTH-1:0]   bin_q;
  logic [AW-1:0]      acc_q;
  logic [CW-1:0]      count_q;
  logic [AW-1:0]      acc_adj;
  logic [AW+WIDTH-1:0] shifted;
  logic [WIDTH-1:0]   magnitude;
  logic               last_shift;
  logic               accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (acc_q[4*g +: 4]),
      .adjusted (acc_adj[4*g +: 4])
    );
  end

  assign shifted    = {acc_adj, bin_q} << 1;
  assign last_shift = (count_q == CW'(1));
  assign accept     = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)      state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // The final shift result goes straight into digits, so they only ever move on the DONE entry edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      digits  <= '0;
    end else if (accept) begin
      bin_q   <= magnitude;
      acc_q   <= '0;
      count_q <= CW'(WIDTH);
    end else if (state == SHIFT) begin
      {acc_q, bin_q} <= shifted;
      count_q        <= count_q - 1'b1;
      if (last_shift) begin
        digits <= shifted[AW+WIDTH-1 -: AW];
      end
    end
  end

`ifdef SIGNED_INPUT_EN
  logic sign_q;

  // Negating in WIDTH bits maps the most negative input onto its exact unsigned magnitude.
  assign magnitude = value[WIDTH-1] ? (WIDTH'(0) - value) : value;

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
      neg    <= 1'b0;
    end else if (accept) begin
      sign_q <= value[WIDTH-1];
    end else if ((state == SHIFT) && last_shift) begin
      neg <= sign_q;
    end
  end
`else
  assign magnitude = value;
  assign neg       = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, binary operand width in bits.
REQ-002 SHALL have parameter DIGITS, default 5, BCD digits produced, at least ceil(WIDTH*log10(2)).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request conversion of value, sampled only in IDLE.
REQ-006 SHALL have port value  input  WIDTH  calculator result to convert.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking new digits valid.
REQ-009 SHALL have port digits  output  4*DIGITS  packed BCD nibbles, nibble 0 (bits 3:0) least significant; each nibble drives one downstream hex_display val input.
REQ-010 SHALL have port neg  output  1  sign of converted value, for a downstream minus-segment.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 SHALL latch magnitude of value into a WIDTH-bit shift register, clear the BCD accumulator, load the shift counter with WIDTH, latch the sign, and enter SHIFT.
REQ-013 SHIFT SHALL, each cycle, add 3 to every accumulator digit >= 5, then shift {accumulator, binary register} left by one bit, and decrement the counter.
REQ-014 SHIFT SHALL enter DONE on the edge that performs the WIDTH-th shift, registering the accumulator into digits and the latched sign into neg on that same edge.
REQ-015 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-016 Latency SHALL be fixed: done high in the cycle following the WIDTH-th edge after the start-sampling edge (16 edges for WIDTH=16), independent of value.
REQ-017 start SHALL be ignored in SHIFT and DONE; no queuing; back-to-back requests are accepted at the earliest next IDLE cycle.
REQ-018 digits and neg SHALL hold their last values between done pulses and SHALL NOT change during SHIFT.
REQ-019 Every output nibble SHALL be in 0..9; leading digits SHALL be 0 (no blanking).
REQ-020 value changes after the sampling edge SHALL NOT affect the conversion in progress.
REQ-021 Magnitude SHALL be computed in WIDTH unsigned bits so the most negative input converts exactly (-32768 -> 32768).

Reset
REQ-022 reset=1 SHALL force IDLE, busy=0, done=0, digits all zero, neg=0, counter and internal registers zero.
REQ-023 reset during SHIFT or DONE SHALL abort the conversion with no done pulse; reset SHALL take priority over start in the same cycle.

Configuration
REQ-024 With SIGNED_INPUT_EN defined, value SHALL be two's complement; neg=1 and magnitude=-value for negative inputs.
REQ-025 Without SIGNED_INPUT_EN, value SHALL be unsigned, neg SHALL be constant 0, and the negate logic SHALL be absent.

Structure
REQ-026 Package calc_display_pkg SHALL hold bcd_digit_t (4-bit), the FSM state enum, and default WIDTH/DIGITS constants shared with the display path.
REQ-027 Combinational sub-module bcd_digit_adj (digit in, digit+3 if >=5 out) SHALL be instantiated once per digit; all sequencing SHALL stay in bin_to_bcd_seq.

Verification
REQ-028 value=1234, start pulse -> done 16 edges later, digits=0x01234, neg=0, busy high exactly 17 cycles.
REQ-029 SIGNED_INPUT_EN, value=16'h8000 -> digits=0x32768, neg=1; value=16'hFFFF -> digits=0x00001, neg=1.
REQ-030 SIGNED_INPUT_EN absent, value=65535 -> digits=0x65535, neg=0; value=0 -> digits=0x00000.
REQ-031 start=1 continuously with value=42 then value=7 changed mid-SHIFT -> first done gives 0x00042, next conversion accepted the cycle after DONE, no start lost or doubled.
REQ-032 reset asserted at SHIFT cycle 8 of 9999 -> no done, digits stay 0x00000, next start with 9999 -> 0x09999 after the full latency.
